// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use bubbles, branch flushes
// and multicycle-op holds with a watchdog that forces release after MC_TIMEOUT cycles.
module hazard_ctrl #(
   parameter int unsigned MC_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  de_rs1,
   input  logic [4:0]  de_rs2,
   input  logic [4:0]  ex_rs1,
   input  logic [4:0]  ex_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   input  logic [1:0]  ex_result_src,
   input  logic        ex_pc_src,
   input  logic [4:0]  mem_rd,
   input  logic        mem_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic        wb_reg_write,
   input  logic        ex_mc_start,
   input  logic        mc_done,
   output logic [1:0]  ex_op1_forward,
   output logic [1:0]  ex_op2_forward,
   output logic        if_stall,
   output logic        de_stall,
   output logic        ex_stall,
   output logic        de_clear,
   output logic        ex_clear,
   output logic        mem_clear,
   output logic        mc_busy,
   output logic        mc_timeout,
   output logic [15:0] stall_count
);

   typedef enum logic {RUN, MC_WAIT} state_t;

   localparam logic [7:0] MC_LAST = 8'(MC_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  mc_cnt_q, mc_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        timeout_q, timeout_d;
   logic        load_use;
   logic        mc_expired;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] m_rd, input logic m_we,
                                          input logic [4:0] w_rd, input logic w_we);
      if (m_we && (m_rd != 5'd0) && (m_rd == rs))
         return 2'b10;
      else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign load_use = (ex_result_src == 2'b01) && ex_reg_write && (ex_rd != 5'd0) &&
                     ((ex_rd == de_rs1) || (ex_rd == de_rs2));
   assign mc_expired = (mc_cnt_q == MC_LAST);

   always_comb begin
      state_d        = state_q;
      mc_cnt_d       = mc_cnt_q;
      timeout_d      = timeout_q;
      ex_op1_forward = 2'b00;
      ex_op2_forward = 2'b00;
      if_stall       = 1'b0;
      de_stall       = 1'b0;
      ex_stall       = 1'b0;
      de_clear       = 1'b0;
      ex_clear       = 1'b0;
      mem_clear      = 1'b0;
      mc_busy        = 1'b0;
      if (reset) begin
         de_clear  = 1'b1;
         ex_clear  = 1'b1;
         mem_clear = 1'b1;
      end else begin
         ex_op1_forward = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
         ex_op2_forward = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
         case (state_q)
            RUN: begin
               if (ex_mc_start && !mc_done) begin
                  if_stall  = 1'b1;
                  de_stall  = 1'b1;
                  ex_stall  = 1'b1;
                  mem_clear = 1'b1;
                  mc_cnt_d  = 8'd0;
                  state_d   = MC_WAIT;
               end else if (ex_mc_start) begin
                  // multicycle unit finished in one cycle: behaves like a plain op
               end else if (ex_pc_src) begin
                  de_clear = 1'b1;
                  ex_clear = 1'b1;
               end else if (load_use) begin
                  if_stall = 1'b1;
                  de_stall = 1'b1;
                  ex_clear = 1'b1;
               end
            end
            MC_WAIT: begin
               mc_busy = 1'b1;
               // an expired watchdog releases EX exactly as a real completion would
               if (mc_done || mc_expired) begin
                  state_d = RUN;
                  if (!mc_done)
                     timeout_d = 1'b1;
               end else begin
                  if_stall  = 1'b1;
                  de_stall  = 1'b1;
                  ex_stall  = 1'b1;
                  mem_clear = 1'b1;
                  mc_cnt_d  = mc_cnt_q + 8'd1;
               end
            end
            default: state_d = RUN;
         endcase
      end
      stall_cnt_d = stall_cnt_q;
      if (if_stall && (stall_cnt_q != 16'hFFFF))
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         mc_cnt_q    <= 8'd0;
         stall_cnt_q <= 16'd0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mc_cnt_q    <= mc_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign mc_timeout  = timeout_q;
   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected output vectors are queued with each
// stimulus step and popped for comparison mid-cycle, away from the rising edge.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic        ex_reg_write, ex_pc_src, mem_reg_write, wb_reg_write, ex_mc_start, mc_done;
   logic [1:0]  ex_result_src;
   logic [1:0]  ex_op1_forward, ex_op2_forward;
   logic        if_stall, de_stall, ex_stall, de_clear, ex_clear, mem_clear, mc_busy, mc_timeout;
   logic [15:0] stall_count;

   int total = 0;
   int bad   = 0;

   logic [27:0] exp_q[$];
   string       tag_q[$];

   hazard_ctrl #(.MC_TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .de_rs1(de_rs1), .de_rs2(de_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_result_src(ex_result_src), .ex_pc_src(ex_pc_src),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .ex_mc_start(ex_mc_start), .mc_done(mc_done),
      .ex_op1_forward(ex_op1_forward), .ex_op2_forward(ex_op2_forward),
      .if_stall(if_stall), .de_stall(de_stall), .ex_stall(ex_stall),
      .de_clear(de_clear), .ex_clear(ex_clear), .mem_clear(mem_clear),
      .mc_busy(mc_busy), .mc_timeout(mc_timeout), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // {f1, f2, if, de, ex stall, de/ex/mem clear, busy, timeout, stall_count}
   function automatic logic [27:0] ev(input logic [1:0] f1, input logic [1:0] f2,
                                      input logic is, input logic ds, input logic es,
                                      input logic dc, input logic ec, input logic mc,
                                      input logic bz, input logic to, input logic [15:0] sc);
      return {f1, f2, is, ds, es, dc, ec, mc, bz, to, sc};
   endfunction

   task automatic idle_inputs();
      de_rs1 = 5'd0; de_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
      mem_rd = 5'd0; wb_rd = 5'd0; ex_reg_write = 1'b0; ex_pc_src = 1'b0;
      mem_reg_write = 1'b0; wb_reg_write = 1'b0; ex_mc_start = 1'b0; mc_done = 1'b0;
      ex_result_src = 2'b00;
   endtask

   // Inputs are already applied at the falling edge; check 2 time units later.
   task automatic check(input string tag, input logic [27:0] e);
      logic [27:0] obs;
      logic [27:0] exp_v;
      string       t;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      #2;
      obs   = {ex_op1_forward, ex_op2_forward, if_stall, de_stall, ex_stall,
               de_clear, ex_clear, mem_clear, mc_busy, mc_timeout, stall_count};
      exp_v = exp_q.pop_front();
      t     = tag_q.pop_front();
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", t, obs, exp_v);
      end
      @(negedge clk);
   endtask

   task automatic load_use_inputs();
      ex_result_src = 2'b01; ex_reg_write = 1'b1; ex_rd = 5'd3; de_rs2 = 5'd3;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      mem_rd = 5'd5; wb_rd = 5'd5; ex_rs1 = 5'd5; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
      @(negedge clk);
      check("reset_outputs", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0, 0, 16'd0));

      reset = 1'b0;
      check("fwd_mem_over_wb", ev(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0));

      wb_rd = 5'd7; ex_rs2 = 5'd7;
      check("fwd_wb_op2", ev(2'b10, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0));

      mem_rd = 5'd0; ex_rs1 = 5'd0; wb_rd = 5'd0; ex_rs2 = 5'd0;
      check("fwd_x0_none", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0));

      idle_inputs(); load_use_inputs();
      check("load_use_bubble", ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0, 16'd0));
      idle_inputs();
      check("after_load_use", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 16'd1));

      load_use_inputs(); ex_rd = 5'd0; de_rs2 = 5'd0;
      check("load_rd0_no_stall", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 16'd1));

      idle_inputs(); load_use_inputs(); ex_pc_src = 1'b1;
      check("flush_over_load_use", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 16'd1));
      idle_inputs();
      check("after_flush", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 16'd1));

      // restart the stall counter so the multicycle op is counted from zero
      reset = 1'b1;
      check("reset_pulse", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0, 0, 16'd0));
      reset = 1'b0;
      ex_mc_start = 1'b1;
      check("mc_start", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 0, 16'd0));
      check("mc_wait1", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 0, 16'd1));
      load_use_inputs(); ex_pc_src = 1'b1;
      check("mc_wait2_ignore_flush", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 0, 16'd2));
      idle_inputs(); ex_mc_start = 1'b1; mem_rd = 5'd4; ex_rs2 = 5'd4; mem_reg_write = 1'b1;
      check("mc_wait3_fwd", ev(2'b00, 2'b10, 1, 1, 1, 0, 0, 1, 1, 0, 16'd3));
      idle_inputs(); ex_mc_start = 1'b1; mc_done = 1'b1;
      check("mc_done_release", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 16'd4));
      idle_inputs();
      check("mc_back_run", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 16'd4));

      ex_mc_start = 1'b1; mc_done = 1'b1;
      check("mc_single_cycle", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 16'd4));
      idle_inputs();
      check("mc_single_after", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 16'd4));

      ex_mc_start = 1'b1;
      check("to_start", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 0, 16'd4));
      for (int k = 1; k <= 7; k++)
         check($sformatf("to_wait%0d", k), ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 0, 16'(4 + k)));
      check("to_forced_release", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 16'd12));
      idle_inputs();
      check("to_sticky1", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 16'd12));
      check("to_sticky2", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 16'd12));

      ex_mc_start = 1'b1;
      check("ab_start", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0, 1, 16'd12));
      check("ab_wait1", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 1, 16'd13));
      check("ab_wait2", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 1, 16'd14));
      idle_inputs(); reset = 1'b1;
      check("ab_reset_mid_wait", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0, 0, 16'd0));
      reset = 1'b0;
      check("ab_after_release", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0));
      check("ab_run_steady", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
